// File: rtl/dac_pkg.sv
// Shared constants and FSM state type for the DAC sample scheduler.
// Midscale-on-underrun behaviour is selected by DAC_MIDSCALE_IDLE_EN.
package dac_pkg;

  localparam int DAC_DW = 8;
  localparam logic [DAC_DW-1:0] DAC_MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } dac_state_t;

endpackage

// File: rtl/dac_rr_arbiter.sv
// Rotate-priority search: first requester after 'last', with wrap.
// Purely combinational; grant is meaningful only when any=1.
module dac_rr_arbiter #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  last,
  output logic [NCH-1:0] gnt_onehot,
  output logic [SW-1:0]  gnt_idx,
  output logic           any
);

  logic [SW-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = SW'((int'(last) + i) % NCH);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Time-multiplexes one DAC between NCH sources on a divided tick.
// Define DAC_MIDSCALE_IDLE_EN to drive midscale on underrun ticks.
module dac_sample_scheduler
  import dac_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = DAC_DW,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [DIV_W-1:0]        div,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH-1:0]          s_valid,
  input  logic [NCH*DW-1:0]       s_data,
  output logic [NCH-1:0]          s_ready,
  output logic [DW-1:0]           dout,
  output logic [$clog2(NCH)-1:0]  dsel,
  output logic                    dstrobe,
  output logic                    underrun
);

  localparam int SW = $clog2(NCH);

  dac_state_t       state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [SW-1:0]    last;
  logic             tick;

  logic [NCH-1:0]   gnt_onehot;
  logic [SW-1:0]    gnt_idx;
  logic             any;

  dac_rr_arbiter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_arb (
    .req        (ch_en & s_valid),
    .last       (last),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // run=0 in RUN suppresses the tick so no grant races the exit
  assign tick    = (state == RUN) && run && (cnt >= div);
  assign s_ready = tick ? gnt_onehot : '0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (run) state_n = ARM;
      end
      ARM: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        if (!run) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= SW'(NCH - 1);
      dout     <= DAC_MIDSCALE;
      dsel     <= '0;
      dstrobe  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dstrobe  <= 1'b0;
      underrun <= 1'b0;
      if (tick) begin
        if (any) begin
          dout    <= s_data[gnt_idx*DW +: DW];
          dsel    <= gnt_idx;
          dstrobe <= 1'b1;
          last    <= gnt_idx;
        end else begin
          underrun <= 1'b1;
`ifdef DAC_MIDSCALE_IDLE_EN
          dout    <= DAC_MIDSCALE;
          dstrobe <= 1'b1;
`else
          dout    <= dout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: expected {dsel,dout}
// pairs are queued per test and popped on every dstrobe.
module tb_dac_sample_scheduler;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DIV_W = 16;

  logic             clk;
  logic             rst;
  logic             run;
  logic [DIV_W-1:0] div;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   s_valid;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]   s_ready;
  logic [DW-1:0]    dout;
  logic [1:0]       dsel;
  logic             dstrobe;
  logic             underrun;

  dac_sample_scheduler #(
    .NCH   (NCH),
    .DW    (DW),
    .DIV_W (DIV_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .div      (div),
    .ch_en    (ch_en),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .dout     (dout),
    .dsel     (dsel),
    .dstrobe  (dstrobe),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_gr(input int k);
    return 32'((k << 8) | (16 * (k + 1)));
  endfunction

  logic [31:0] sb[$];
  int cyc = 0;
  int epoch = 0;
  int exp_period = 0;
  int prev_epoch = -1;
  int prev_cyc = 0;
  int first_cyc = 0;
  int upulses = 0;
  int nstrobe = 0;
  int sr_cnt = 0;
  int sr_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_ready != 0) sr_cnt <= sr_cnt + 1;
      if ((s_ready & ~ch_en) != 0 || (s_ready & (s_ready - 1)) != 0)
        sr_bad <= sr_bad + 1;
      if (underrun) upulses <= upulses + 1;
      if (dstrobe) begin
        nstrobe <= nstrobe + 1;
        chk("strobe", {22'd0, dsel, dout},
            sb.size() > 0 ? sb.pop_front() : 32'hFFFF);
        if (prev_epoch != epoch)
          first_cyc <= cyc;
        else if (exp_period != 0)
          chk("period", 32'(cyc - prev_cyc), 32'(exp_period));
        prev_cyc   <= cyc;
        prev_epoch <= epoch;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(sb.size()), 0);
  endtask

  int base, sbase, rbase, n, c;

  initial begin
    rst     = 1'b1;
    run     = 1'b0;
    div     = 16'd9;
    ch_en   = 4'hF;
    s_valid = 4'hF;
    s_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    #12;
    chk("rst_dout", 32'(dout), 32'h80);
    chk("rst_dsel", 32'(dsel), 0);
    chk("rst_strobe", 32'(dstrobe), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sready", 32'(s_ready), 0);

    // idle with everything valid
    step(1);
    rst = 1'b0;
    sbase = nstrobe;
    rbase = sr_cnt;
    step(50);
    chk("idle_dout", 32'(dout), 32'h80);
    chk("idle_sready", 32'(sr_cnt - rbase), 0);
    chk("idle_strobes", 32'(nstrobe - sbase), 0);

    // pacing: div=9 -> period 10, round robin from ch0
    epoch++;
    exp_period = 10;
    for (int i = 0; i < 6; i++) sb.push_back(exp_gr(i % 4));
    run = 1'b1;
    wait_empty("pace_done", 200);
    run = 1'b0;
    step(12);

    // mask: only ch0/ch2 eligible; pointer at ch1 -> ch2 first
    epoch++;
    exp_period = 2;
    div = 16'd1;
    ch_en = 4'b0101;
    rbase = sr_bad;
    for (int i = 0; i < 4; i++) sb.push_back(exp_gr((i % 2 == 0) ? 2 : 0));
    run = 1'b1;
    wait_empty("mask_done", 100);
    run = 1'b0;
    step(6);
    chk("mask_sready", 32'(sr_bad - rbase), 0);

    // underrun: no valid sources, 3 ticks
    epoch++;
    exp_period = 4;
    div = 16'd3;
    ch_en = 4'hF;
    s_valid = 4'h0;
    base = upulses;
    sbase = nstrobe;
    rbase = sr_cnt;
`ifdef DAC_MIDSCALE_IDLE_EN
    for (int i = 0; i < 3; i++) sb.push_back(32'h0080);
`endif
    run = 1'b1;
    n = 0;
    while (upulses - base < 3 && n < 60) begin
      step(1);
      n++;
    end
    run = 1'b0;
    step(10);
    chk("urun_count", 32'(upulses - base), 3);
    chk("urun_sready", 32'(sr_cnt - rbase), 0);
`ifdef DAC_MIDSCALE_IDLE_EN
    chk("urun_sb", 32'(sb.size()), 0);
    chk("urun_dout", 32'(dout), 32'h80);
`else
    chk("urun_strobes", 32'(nstrobe - sbase), 0);
    chk("urun_dout", 32'(dout), 32'h10);
`endif
    chk("urun_dsel", 32'(dsel), 0);

    // div=0: a grant every clock, pointer resumes after ch0
    epoch++;
    exp_period = 1;
    div = 16'd0;
    s_valid = 4'hF;
    for (int i = 0; i < 8; i++) sb.push_back(exp_gr((i + 1) % 4));
    run = 1'b1;
    wait_empty("div0_done", 50);
    run = 1'b0;
    step(6);

    // mid-period change: cnt=7 while div 20 -> 2
    epoch++;
    exp_period = 3;
    div = 16'd20;
    for (int i = 1; i <= 3; i++) sb.push_back(exp_gr(i));
    run = 1'b1;
    c = cyc;
    step(9);
    div = 16'd2;
    wait_empty("divchg_done", 40);
    chk("divchg_first", 32'(first_cyc - c), 10);
    run = 1'b0;
    step(6);

    // async reset mid-RUN
    epoch++;
    exp_period = 2;
    div = 16'd1;
    sb.push_back(exp_gr(0));
    sb.push_back(exp_gr(1));
    run = 1'b1;
    wait_empty("arst_pre", 40);
    rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'h80);
    chk("arst_dsel", 32'(dsel), 0);
    chk("arst_strobe", 32'(dstrobe), 0);
    chk("arst_sready", 32'(s_ready), 0);
    step(2);
    epoch++;
    rst = 1'b0;
    sb.push_back(exp_gr(0));
    wait_empty("arst_post", 40);
    run = 1'b0;
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
